alu_scheduler: RTL
==================

// Module: alu_scheduler
// PURPOSE
//  Shares one 12-bit ALU between two requesters. Round-robin arbitration, one
//  transaction in flight, result routed back to the issuing requester. A lock
//  bit keeps the ALU on one requester so MAC accumulation sequences are never
//  interleaved. A watchdog bounds the wait for the ALU result.
// PARAMETERS
//  DATA_W   12  operand/result width
//  INST_W   3   opcode width (ADD,SUB,MUL,MAC,XNOR,RELU,MEAN,ABSMAX = 0..7)
//  TIMEOUT  8   max cycles in WAIT before an error response (>=2)
// PORTS
//  i_clk            in   1         clock, all logic on rising edge
//  i_rst            in   1         reset, synchronous, active-high
//  i_req_valid      in   2         per-requester request valid
//  o_req_ready      out  2         per-requester request accept
//  i_req_a          in   2*DATA_W  operand A, requester k at [k*DATA_W +: DATA_W]
//  i_req_b          in   2*DATA_W  operand B, same packing
//  i_req_inst       in   2*INST_W  opcode, requester k at [k*INST_W +: INST_W]
//  i_req_lock       in   2         keep grant with this requester after this txn
//  o_alu_valid      out  1         one-cycle issue strobe to ALU
//  o_alu_a/o_alu_b  out  DATA_W    issued operands
//  o_alu_inst       out  INST_W    issued opcode
//  i_alu_valid      in   1         ALU result valid
//  i_alu_data       in   DATA_W    ALU result
//  i_alu_overflow   in   1         ALU overflow flag
//  o_rsp_valid      out  2         one-hot response valid, bit k = requester k
//  i_rsp_ready      in   2         per-requester response accept
//  o_rsp_data       out  DATA_W    response data (shared)
//  o_rsp_overflow   out  1         captured overflow
//  o_rsp_timeout    out  1         1 = watchdog expired, data/overflow forced 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=1 (req0 wins first), lock clear.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  IDLE: winner = valid requester != last_grant; else the single valid one.
//   If lock set, only lock owner eligible. o_req_ready is combinational,
//   asserted only for the winner, only in IDLE. valid&ready latches a/b/inst/lock.
//  ISSUE: o_alu_valid=1 exactly one cycle with latched operands; counter cleared.
//  WAIT: i_alu_valid -> latch data/overflow, go RESP. Counter increments each
//   cycle; at TIMEOUT with no i_alu_valid -> RESP, timeout=1, data=0, ovf=0.
//   i_alu_valid in the expiry cycle wins: normal response, timeout=0.
//  RESP: o_rsp_valid[k]=1, data/flags held stable until i_rsp_ready[k];
//   then last_grant=k, lock owner=k if latched lock=1, else lock cleared; IDLE.
//  i_alu_valid outside WAIT ignored. i_rsp_ready[j], j!=k, ignored.
//  Min 4 cycles per transaction; no request accepted outside IDLE.
//  Lock holder may starve the other requester; by design (MAC chains finite).
//  Reset mid-op: next cycle IDLE, all outputs 0, pending txn dropped, no response.
//  Timeout response also releases lock (owner must re-lock).
// STRUCTURE
//  Package alu_ctrl_pkg: state encoding localparams, opcode localparams
//   (OP_ADD..OP_ABSMAX), DATA_W/INST_W defaults.
//  Sub-module rr_arbiter_2: 2-way round-robin with eligibility mask
//   (lock) and last_grant input; returns one-hot grant, zero if none eligible.
//  Top holds FSM, operand/result registers, watchdog counter, lock owner.
// TESTING
//  req0 ADD a=12'h005 b=12'h003 -> o_alu_valid 1 cycle, inst=0; ALU returns
//   12'h008 -> o_rsp_valid=2'b01, data=12'h008, ovf=0, timeout=0.
//  Both valid from reset, 4 txns each -> grant order 0,1,0,1,...; each
//   o_alu_valid pulse carries the granted requester's operands.
//  req0 MAC lock=1 twice then lock=0, req1 valid throughout -> req0 served
//   3 times back-to-back, req1 served 4th.
//  ALU silent after issue -> after 8 WAIT cycles o_rsp_valid[k]=1,
//   timeout=1, data=0; i_alu_valid=1 on cycle 8 -> normal response instead.
//  i_rsp_ready low 5 cycles in RESP -> rsp outputs stable, o_req_ready=2'b00.
//  i_rst pulsed in WAIT with lock set -> next cycle all outputs 0, late
//   i_alu_valid ignored, next txn granted to req0 with lock clear.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU scheduler.
// FSM state encoding, opcode values, default widths.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int INST_W_DEF = 3;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_MAC    = 3'd3;
  localparam logic [2:0] OP_XNOR   = 3'd4;
  localparam logic [2:0] OP_RELU   = 3'd5;
  localparam logic [2:0] OP_MEAN   = 3'd6;
  localparam logic [2:0] OP_ABSMAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with eligibility mask.
// Ports: i_req, i_elig, i_last (last winner) -> o_grant one-hot or zero.
module rr_arbiter_2
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_elig,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  logic [1:0] cand;

  always_comb begin
    cand    = i_req & i_elig;
    o_grant = cand;
    // contention: the requester that did not win last time goes first
    if (cand == 2'b11) o_grant = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between two requesters: round-robin, lock, watchdog.
// Ports: req valid/ready/a/b/inst/lock, ALU issue/result, one-hot response.
module alu_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INST_W  = INST_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*DATA_W-1:0] i_req_a,
  input  logic [2*DATA_W-1:0] i_req_b,
  input  logic [2*INST_W-1:0] i_req_inst,
  input  logic [1:0]          i_req_lock,
  output logic                o_alu_valid,
  output logic [DATA_W-1:0]   o_alu_a,
  output logic [DATA_W-1:0]   o_alu_b,
  output logic [INST_W-1:0]   o_alu_inst,
  input  logic                i_alu_valid,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic                i_alu_overflow,
  output logic [1:0]          o_rsp_valid,
  input  logic [1:0]          i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_overflow,
  output logic                o_rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                lock_q, lock_d;
  logic                own_q, own_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;
  logic                last_q, last_d;
  logic                lk_act_q, lk_act_d;
  logic                lk_own_q, lk_own_d;

  logic [1:0] elig;
  logic [1:0] grant;
  logic       rsp_on;

  assign elig = lk_act_q ? (lk_own_q ? 2'b10 : 2'b01) : 2'b11;

  rr_arbiter_2 u_arb (
    .i_req   (i_req_valid),
    .i_elig  (elig),
    .i_last  (last_q),
    .o_grant (grant)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    inst_d      = inst_q;
    lock_d      = lock_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    to_d        = to_q;
    last_d      = last_q;
    lk_act_d    = lk_act_q;
    lk_own_d    = lk_own_q;
    o_req_ready = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        // no handshake is offered while reset is held
        o_req_ready = grant & {2{~i_rst}};
        if (|grant) begin
          own_d   = grant[1];
          a_d     = grant[1] ? i_req_a[DATA_W +: DATA_W]
                             : i_req_a[0 +: DATA_W];
          b_d     = grant[1] ? i_req_b[DATA_W +: DATA_W]
                             : i_req_b[0 +: DATA_W];
          inst_d  = grant[1] ? i_req_inst[INST_W +: INST_W]
                             : i_req_inst[0 +: INST_W];
          lock_d  = grant[1] ? i_req_lock[1] : i_req_lock[0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_alu_valid) begin
          data_d  = i_alu_data;
          ovf_d   = i_alu_overflow;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          ovf_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (i_rsp_ready[own_q]) begin
          last_d   = own_q;
          // an expired transaction drops any lock request
          lk_act_d = lock_q & ~to_q;
          lk_own_d = own_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      inst_q   <= '0;
      lock_q   <= 1'b0;
      own_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      last_q   <= 1'b1;
      lk_act_q <= 1'b0;
      lk_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      inst_q   <= inst_d;
      lock_q   <= lock_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      last_q   <= last_d;
      lk_act_q <= lk_act_d;
      lk_own_q <= lk_own_d;
    end
  end

  assign o_alu_valid    = (state_q == ST_ISSUE);
  assign o_alu_a        = o_alu_valid ? a_q : '0;
  assign o_alu_b        = o_alu_valid ? b_q : '0;
  assign o_alu_inst     = o_alu_valid ? inst_q : '0;
  assign rsp_on         = (state_q == ST_RESP);
  assign o_rsp_valid    = rsp_on ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data     = rsp_on ? data_q : '0;
  assign o_rsp_overflow = rsp_on & ovf_q;
  assign o_rsp_timeout  = rsp_on & to_q;

endmodule
